// File: rtl/lsu_axil_master_if.sv
// lsu_axil_master_if: AXI4-Lite AW/W/B/AR/R channel bundle; master drives addr/data/valid/bready/rready, slave drives ready/resp/rdata/valid.
interface lsu_axil_master_if;
  logic [31:0] awaddr;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  modport master(
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave(
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/lsu_axil_master.sv
// lsu_axil_master: start-edge launched single-outstanding AXI4-Lite master (i_clk/i_rst, i_start_*/i_addr/i_wdata/i_wstrb in, m bus, o_rdata/o_resp/o_busy/o_done/o_timeout/o_overrun out) with watchdog abort.
module lsu_axil_master #(
  parameter int TIMEOUT = 1024
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start_write,
  input  logic                     i_start_read,
  input  logic [31:0]              i_addr,
  input  logic [31:0]              i_wdata,
  input  logic [3:0]               i_wstrb,
  lsu_axil_master_if.master        m,
  output logic [31:0]              o_rdata,
  output logic [1:0]               o_resp,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_timeout,
  output logic                     o_overrun
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;
  state_t state, state_n;
  logic start_wr_q, start_rd_q, aw_done, w_done;
  logic [31:0] addr_q, wdata_q;
  logic [3:0] wstrb_q;
  logic [CW-1:0] wd;
  logic wr_edge, rd_edge, idle, launch_wr, launch_rd, active, expired, aw_ok, w_ok;
  assign wr_edge   = i_start_write & ~start_wr_q;
  assign rd_edge   = i_start_read & ~start_rd_q;
  assign idle      = state == IDLE;
  assign launch_wr = idle & wr_edge;
  assign launch_rd = idle & rd_edge & ~wr_edge;
  assign active    = ~idle & (state != DONE);
  assign expired   = active & (wd == CW'(TIMEOUT - 1));
  assign aw_ok     = aw_done | m.awready;
  assign w_ok      = w_done | m.wready;
  assign m.awvalid = (state == WR_REQ) & ~aw_done;
  assign m.wvalid  = (state == WR_REQ) & ~w_done;
  assign m.bready  = state == WR_RESP;
  assign m.arvalid = state == RD_REQ;
  assign m.rready  = state == RD_RESP;
  assign m.awaddr  = addr_q;
  assign m.araddr  = addr_q;
  assign m.wdata   = wdata_q;
  assign m.wstrb   = wstrb_q;
  assign o_busy    = ~idle;
  assign o_done    = state == DONE;
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = launch_wr ? WR_REQ : launch_rd ? RD_REQ : IDLE;
      WR_REQ:  state_n = expired ? DONE : (aw_ok & w_ok) ? WR_RESP : WR_REQ;
      WR_RESP: state_n = (expired | m.bvalid) ? DONE : WR_RESP;
      RD_REQ:  state_n = expired ? DONE : m.arready ? RD_RESP : RD_REQ;
      RD_RESP: state_n = (expired | m.rvalid) ? DONE : RD_RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      start_wr_q <= 1'b0;
      start_rd_q <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wd         <= '0;
      o_rdata    <= '0;
      o_resp     <= '0;
      o_timeout  <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      start_wr_q <= i_start_write;
      start_rd_q <= i_start_read;
      wd         <= idle ? '0 : wd + 1'b1;
      aw_done    <= ~idle & (aw_done | (m.awvalid & m.awready));
      w_done     <= ~idle & (w_done | (m.wvalid & m.wready));
      o_overrun  <= (launch_wr | launch_rd) ? (launch_wr & rd_edge) : (o_overrun | (~idle & (wr_edge | rd_edge)));
      if (launch_wr | launch_rd) begin
        addr_q    <= i_addr;
        wdata_q   <= i_wdata;
        wstrb_q   <= i_wstrb;
        o_timeout <= 1'b0;
      end
      if (expired) begin
        o_resp    <= 2'b10;
        o_timeout <= 1'b1;
      end else if ((state == WR_RESP) & m.bvalid) o_resp <= m.bresp;
      else if ((state == RD_RESP) & m.rvalid) begin
        o_rdata <= m.rdata;
        o_resp  <= m.rresp;
      end
    end
  end
endmodule

// File: doc/lsu_axil_master.md
# lsu_axil_master

AXI4-Lite master that turns the RISC-V core's register-style bus commands (address, data, strobe, start_write/start_read control bits) into complete AXI4-Lite write and read transactions toward the AXI-to-APB bridge. It sits between the core's LSU-mapped AXI control registers and the bridge. It returns read data (RDATA) and completion status to the core. One transaction is in flight at a time, and a watchdog prevents a hung slave from locking the core.

## Interface
Parameters:
- TIMEOUT, default 1024: cycles allowed from launch to final handshake before abort; counter width is $clog2(TIMEOUT+1).

Ports:
- i_clk  in  1  clock; all logic is on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start_write  in  1  control reg bit 0; level signal, and its rising edge launches a write.
- i_start_read  in  1  control reg bit 1; level signal, and its rising edge launches a read.
- i_addr  in  32  transaction address.
- i_wdata  in  32  write data.
- i_wstrb  in  4  write byte strobes.
- m_awaddr/m_awvalid  out  32/1, m_awready  in  1: write address channel.
- m_wdata/m_wstrb/m_wvalid  out  32/4/1, m_wready  in  1: write data channel.
- m_bresp  in  2, m_bvalid  in  1, m_bready  out  1: write response channel.
- m_araddr/m_arvalid  out  32/1, m_arready  in  1: read address channel.
- m_rdata  in  32, m_rresp  in  2, m_rvalid  in  1, m_rready  out  1: read data channel.
- o_rdata  out  32  last read data, held until the next read completes.
- o_resp  out  2  BRESP/RRESP of the last completed transaction.
- o_busy  out  1  high from the launch cycle+1 until return to IDLE.
- o_done  out  1  one-cycle completion pulse.
- o_timeout  out  1  sticky; the last transaction was aborted.
- o_overrun  out  1  sticky; a start edge was dropped while busy.

## Operation
- Edge detect: registers start_wr_q and start_rd_q. A launch occurs when the state is IDLE and (start & ~start_q) is true.
- At launch, i_addr, i_wdata and i_wstrb are captured into internal registers. The AXI outputs are driven only from these captured registers.
- If both edges occur in the same cycle, the write wins. The read edge is dropped and o_overrun is set.
- A start edge seen in any non-IDLE state is dropped and sets o_overrun.
- Every accepted launch clears o_timeout and o_overrun.
- States:
  - IDLE: all valids and readies are low.
  - WR_REQ: m_awvalid and m_wvalid are asserted together. Each channel is dropped independently on its own handshake, and acceptance may occur in any order or in the same cycle. When both are accepted, go to WR_RESP.
  - WR_RESP: m_bready=1. On bvalid, capture bresp and go to DONE.
  - RD_REQ: m_arvalid=1. On arready, go to RD_RESP.
  - RD_RESP: m_rready=1. On rvalid, capture rdata and rresp and go to DONE.
  - DONE: o_done=1 for one cycle, then go to IDLE.
- Valid signals never drop before their handshake, except on timeout or reset.
- Watchdog: the counter clears at launch and increments every busy cycle. When it reaches TIMEOUT in any of WR_REQ, WR_RESP, RD_REQ or RD_RESP:
  - all valids and readies drop the next cycle;
  - o_timeout is set, o_resp becomes 2'b10 (SLVERR), and o_rdata is unchanged;
  - the block passes through DONE, so o_done still pulses.
- After a timeout abort, a late bvalid or rvalid is ignored because ready stays low in IDLE.

## Timing
- Reset values: state IDLE; start_q=0; every m_*valid and m_*ready = 0; m_awaddr, m_araddr and m_wdata = 0; m_wstrb=0; o_rdata=0; o_resp=0; o_busy=0; o_done=0; o_timeout=0; o_overrun=0; watchdog=0.
- Reset mid-transaction aborts immediately, with no o_done and no flag update.
- Start edge in cycle N: the valid(s) and o_busy are high in cycle N+1.
- Final handshake (bvalid&bready or rvalid&rready) in cycle M: o_done, o_rdata and o_resp are updated in cycle M+1, and o_busy is low in M+2.
- Minimum write with zero-wait slave: launch N, AW+W accepted N+1, B accepted N+2, done N+3. Reads follow the same pattern.
- A held start level does not relaunch; the bit must return to 0 first.

## Test plan
- Write with zero-wait slave: i_addr=0x4000_0004, i_wdata=0xA5A5_1234, i_wstrb=4'hF, start_write 0->1 -> AW/W carry those values in N+1, o_done in N+3, o_resp=0, o_busy falls in N+4.
- Split write: the slave asserts wready 3 cycles before awready -> wvalid drops after its handshake, awvalid holds until accepted, and exactly one B handshake follows.
- Read: i_addr=0x4000_0008, the slave returns rdata=0x0000_0055 with rresp=0 after 4 wait cycles -> o_rdata=0x55 on the o_done cycle, and the value holds through a following write.
- Simultaneous edges: start_write and start_read rise together -> write executes, no AR is issued, o_overrun=1. A later clean read launch clears o_overrun.
- Timeout: TIMEOUT=16 and the slave never asserts arready -> arvalid drops after 16 cycles, o_timeout=1, o_resp=2'b10, o_done pulses, and a late rvalid is ignored.
- i_rst asserted while in WR_RESP -> next cycle all outputs are at reset values, no o_done, and a fresh launch completes normally.
